// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline-register chain: DEPTH stages of WIDTH-bit payload with
// per-stage hold (propagated upstream), bubble insertion, flush and retire counting.

module pipe_stage_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             eff_hold,
    input  logic             up_hold,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q,
    output logic             valid_d
);
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (!eff_hold) begin
            // upstream frozen but we are free: emit a bubble instead of duplicating
            if (up_hold) begin
                data_d  = '0;
                valid_d = 1'b0;
            end else begin
                data_d  = up_data;
                valid_d = up_valid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
endmodule

module pipe_stage_chain #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DEPTH-1:0]           hold,
    input  logic [DEPTH-1:0]           flush,
    output logic [WIDTH*DEPTH-1:0]     stage_data,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic [CNT_W-1:0]           retired
);
    localparam int IW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] up_data;
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [DEPTH-1:0]            up_valid;
    logic [DEPTH-1:0]            up_hold;
    logic [DEPTH-1:0]            eff_hold;
    logic [IW-1:0]               inflight_d, inflight_q;
    logic [CNT_W-1:0]            retired_d, retired_q;
    logic                        retire;

    // a hold anywhere downstream freezes this stage too
    always_comb begin
        eff_hold = '0;
        for (int i = 0; i < DEPTH; i++)
            eff_hold[i] = |(hold >> i);
    end

    always_comb begin
        up_data    = '0;
        up_data[0] = in_data;
        for (int i = 1; i < DEPTH; i++)
            up_data[i] = data_q[i-1];
    end

    assign up_valid = {valid_q[DEPTH-2:0], in_valid};
    assign up_hold  = {eff_hold[DEPTH-2:0], 1'b0};

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage_slot #(.WIDTH(WIDTH)) u_slot (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush[g]),
            .eff_hold (eff_hold[g]),
            .up_hold  (up_hold[g]),
            .up_data  (up_data[g]),
            .up_valid (up_valid[g]),
            .data_q   (data_q[g]),
            .valid_q  (valid_q[g]),
            .valid_d  (valid_d[g])
        );
    end

    assign retire = valid_q[DEPTH-1] & ~eff_hold[DEPTH-1] & ~flush[DEPTH-1];

    always_comb begin
        inflight_d = '0;
        for (int i = 0; i < DEPTH; i++)
            inflight_d = inflight_d + IW'(valid_d[i]);
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= '0;
            retired_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            retired_q  <= retired_d;
        end
    end

    assign in_ready    = ~eff_hold[0];
    assign stage_data  = data_q;
    assign stage_valid = valid_q;
    assign out_data    = data_q[DEPTH-1];
    assign out_valid   = valid_q[DEPTH-1];
    assign inflight    = inflight_q;
    assign retired     = retired_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: stream, stall/bubble, flush, reset and
// a narrow-counter instance for retire wrap and last-stage hold.

module tb_pipe_stage_chain;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  hold, flush;
    logic [63:0] stage_data;
    logic [3:0]  stage_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  inflight;
    logic [15:0] retired;

    logic        w_reset;
    logic [15:0] w_in_data;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [3:0]  w_hold, w_flush;
    logic [63:0] w_stage_data;
    logic [3:0]  w_stage_valid;
    logic [15:0] w_out_data;
    logic        w_out_valid;
    logic [2:0]  w_inflight;
    logic [3:0]  w_retired;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pipe_stage_chain #(.WIDTH(16), .DEPTH(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .hold(hold), .flush(flush), .stage_data(stage_data),
        .stage_valid(stage_valid), .out_data(out_data), .out_valid(out_valid),
        .inflight(inflight), .retired(retired)
    );

    pipe_stage_chain #(.WIDTH(16), .DEPTH(4), .CNT_W(4)) dut_w (
        .clock(clock), .reset(w_reset), .in_data(w_in_data), .in_valid(w_in_valid),
        .in_ready(w_in_ready), .hold(w_hold), .flush(w_flush), .stage_data(w_stage_data),
        .stage_valid(w_stage_valid), .out_data(w_out_data), .out_valid(w_out_valid),
        .inflight(w_inflight), .retired(w_retired)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; hold = '0; flush = '0;
        w_reset = 1'b1; w_in_data = '0; w_in_valid = 1'b0; w_hold = '0; w_flush = '0;
        tick(); tick();
        chk("rst_valid", 64'(stage_valid), 64'h0);
        chk("rst_data", stage_data, 64'h0);
        chk("rst_inflight", 64'(inflight), 64'h0);
        chk("rst_retired", 64'(retired), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);

        // stream without stall
        reset = 1'b0; in_valid = 1'b1;
        in_data = 16'h1111; tick();
        chk("s_first_load", 64'(stage_data[15:0]), 64'h1111);
        chk("s_not_out_yet", 64'(out_valid), 64'h0);
        in_data = 16'h2222; tick();
        in_data = 16'h3333; tick();
        in_data = 16'h4444; tick();
        chk("s_out_4cyc", {47'h0, out_valid, out_data}, {47'h0, 1'b1, 16'h1111});
        chk("s_inflight4", 64'(inflight), 64'd4);
        chk("s_ret_before", 64'(retired), 64'd0);
        in_data = 16'h5555; tick();
        chk("s_out2", 64'(out_data), 64'h2222);
        in_valid = 1'b0; in_data = '0;
        tick(); chk("s_out3", 64'(out_data), 64'h3333);
        tick(); chk("s_out4", 64'(out_data), 64'h4444);
        tick(); chk("s_out5", 64'(out_data), 64'h5555);
        chk("s_inflight1", 64'(inflight), 64'd1);
        tick();
        chk("s_drain_valid", 64'(stage_valid), 64'h0);
        chk("s_retired5", 64'(retired), 64'd5);

        // fill A..D then stall stage 1
        in_valid = 1'b1;
        in_data = 16'h000D; tick();
        in_data = 16'h000C; tick();
        in_data = 16'h000B; tick();
        in_data = 16'h000A; tick();
        chk("b_fill", stage_data, 64'h000D_000C_000B_000A);
        in_data = 16'h000E; hold = 4'b0010; #1;
        chk("b_ready_low", 64'(in_ready), 64'h0);
        tick();
        chk("b1_data", stage_data, 64'h000C_0000_000B_000A);
        chk("b1_valid", 64'(stage_valid), 64'hB);
        chk("b1_retired", 64'(retired), 64'd6);
        tick();
        chk("b2_data", stage_data, 64'h0000_0000_000B_000A);
        chk("b2_valid", 64'(stage_valid), 64'h3);
        chk("b2_retired", 64'(retired), 64'd7);
        hold = 4'b0000; #1;
        chk("b_ready_high", 64'(in_ready), 64'h1);
        tick();
        chk("b_rel1", stage_data, 64'h0000_000B_000A_000E);
        chk("b_rel1_valid", 64'(stage_valid), 64'h7);
        in_data = 16'hBEEF; tick();
        chk("b_rel2", {47'h0, out_valid, out_data}, {47'h0, 1'b1, 16'h000B});
        chk("b_rel2_ret", 64'(retired), 64'd7);
        in_data = 16'h0C0C; tick();
        in_data = 16'h0D0D; tick();
        chk("f_pre", stage_data, 64'h000E_BEEF_0C0C_0D0D);
        chk("f_pre_ret", 64'(retired), 64'd9);

        // flush and hold on stage 2 together
        in_data = 16'h0E0E; hold = 4'b0100; flush = 4'b0100; tick();
        chk("fh_data", stage_data, 64'h0000_0000_0C0C_0D0D);
        chk("fh_valid", 64'(stage_valid), 64'h3);
        chk("fh_retired", 64'(retired), 64'd10);
        chk("fh_inflight", 64'(inflight), 64'd2);
        hold = '0; flush = '0; tick();
        in_data = 16'h0F0F; tick();
        chk("bf_pre", stage_data, 64'h0C0C_0D0D_0E0E_0F0F);
        chk("bf_pre_infl", 64'(inflight), 64'd4);

        // branch-style flush of the two youngest stages
        in_data = 16'h1010; flush = 4'b0011; tick();
        chk("bf_data", stage_data, 64'h0D0D_0E0E_0000_0000);
        chk("bf_valid", 64'(stage_valid), 64'hC);
        chk("bf_inflight", 64'(inflight), 64'd2);
        chk("bf_retired", 64'(retired), 64'd11);
        flush = '0;

        // run retired up to 0xFF with a full pipe, then reset mid-stream
        for (int i = 0; i < 246; i++) begin
            in_data = 16'(i);
            tick();
        end
        chk("r_pre_ret", 64'(retired), 64'h00FF);
        chk("r_pre_valid", 64'(stage_valid), 64'hF);
        reset = 1'b1; tick();
        reset = 1'b0; in_valid = 1'b0; #1;
        chk("r_valid", 64'(stage_valid), 64'h0);
        chk("r_data", stage_data, 64'h0);
        chk("r_inflight", 64'(inflight), 64'h0);
        chk("r_retired", 64'(retired), 64'h0);
        chk("r_ready", 64'(in_ready), 64'h1);

        // narrow counter: 17 retirements wrap to 1
        w_reset = 1'b0; w_in_valid = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            w_in_data = 16'(i);
            tick();
        end
        chk("w_wrap", 64'(w_retired), 64'h1);
        chk("w_full", 64'(w_stage_valid), 64'hF);
        w_in_data = 16'd22; w_hold = 4'b1000; #1;
        chk("w_ready_low", 64'(w_in_ready), 64'h0);
        tick(); tick(); tick();
        chk("w_hold_ret", 64'(w_retired), 64'h1);
        chk("w_hold_out", {47'h0, w_out_valid, w_out_data}, {47'h0, 1'b1, 16'd18});
        chk("w_hold_data", w_stage_data, {16'd18, 16'd19, 16'd20, 16'd21});
        w_hold = '0; tick();
        chk("w_rel_ret", 64'(w_retired), 64'h2);
        chk("w_rel_out", 64'(w_out_data), 64'd19);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised pipeline-register chain that replaces the individual per-stage buffers used between CPU stages.
- DEPTH stages of WIDTH-bit payload, each with a valid bit.
- Per-stage hold (stall) with automatic upstream propagation, automatic bubble insertion below a stall, and per-stage flush.
- Exports every stage's contents for forwarding/hazard logic, plus an in-flight count and a retired-instruction counter.

Parameters:
- WIDTH, 16, payload bits per stage.
- DEPTH, 4, number of stages (≥2); stage 0 is the first register after fetch.
- CNT_W, 16, width of retired counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- in_data  in  WIDTH  payload entering stage 0.
- in_valid  in  1  in_data is a real instruction.
- in_ready  out  1  stage 0 accepts this cycle; equals ~eff_hold[0]. Combinational.
- hold  in  DEPTH  hold[i] requests stage i keep its contents.
- flush  in  DEPTH  flush[i] kills stage i's contents at this edge.
- stage_data  out  WIDTH*DEPTH  stage i occupies bits [i*WIDTH +: WIDTH]. Registered.
- stage_valid  out  DEPTH  valid bit per stage. Registered.
- out_data  out  WIDTH  equals stage DEPTH-1 data.
- out_valid  out  1  equals stage_valid[DEPTH-1].
- inflight  out  clog2(DEPTH+1)  popcount of stage_valid. Registered.
- retired  out  CNT_W  count of valid instructions leaving the last stage. Registered.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - all stage data = 0, stage_valid = 0, inflight = 0, retired = 0.
  - Reset asserted mid-stream discards all contents at that edge.
  - First load occurs at the edge after reset deasserts.
- eff_hold[i] = OR of hold[j] for j ≥ i. A stall in stage k freezes stages 0..k; stages above k keep advancing.
- Per-stage next state at each edge, in priority order:
  1. flush[i] → data 0, valid 0. Applies whether or not the stage is held; a flushed held stage becomes a bubble.
  2. eff_hold[i] → data and valid unchanged.
  3. i==0 → data = in_data, valid = in_valid. If in_valid=0, data is loaded anyway (don't-care payload).
  4. i>0 and eff_hold[i-1] → bubble: data 0, valid 0.
  5. otherwise → data = stage i-1 data, valid = stage i-1 valid.
- Latency:
  - With no hold or flush, an item presented with in_valid at edge n appears in stage 0 after edge n and in the last stage after edge n+DEPTH-1.
  - out_valid is visible DEPTH cycles after presentation.
- in_ready is low whenever any hold bit is set. The source must keep in_data/in_valid stable while in_ready=0; the chain ignores the input during those cycles.
- Upstream flush under a stall: flush and hold on the same stage → flush wins. Flush on stage j>k while hold on k → stage j is cleared and stage k stays frozen.
- The last stage has no downstream. hold[DEPTH-1] freezes the whole chain; the frozen last-stage item is not re-counted as retired.
- retired:
  - increments by 1 at each edge where stage_valid[DEPTH-1]=1, eff_hold[DEPTH-1]=0 and flush[DEPTH-1]=0, i.e. the item actually leaves the chain.
  - wraps modulo 2^CNT_W, no saturation.
- inflight is recomputed from the next-state valid bits, so it is registered and consistent with stage_valid in the same cycle.
- No combinational path from hold or flush to stage_data or stage_valid. The only combinational output path is hold → in_ready.

Test Plan:
- Stream, no stall:
  - Stimulus: after reset, present 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 on consecutive cycles, in_valid=1, hold=0, flush=0.
  - Response: out_data=0x1111 with out_valid=1 exactly 4 cycles after first presentation, then one item per cycle; inflight=4 at steady state; retired=5 after the drain finishes.
- Stall with bubble:
  - Stimulus: hold[1]=1 for 2 cycles while stages 0..3 hold A,B,C,D.
  - Response: stages 0 and 1 keep A and B; in_ready=0; stage 2 receives 0 with valid=0 on both cycles; C and D retire; after the hold is released, B follows the two bubbles.
- Flush under hold:
  - Stimulus: hold[2]=1 and flush[2]=1 in the same cycle, with stage 2 = 0xBEEF valid.
  - Response: stage 2 becomes 0 with valid=0; stages 0..1 are unchanged; the retired increment is taken only from stage 3.
- Branch-style flush:
  - Stimulus: flush=4'b0011 with all stages valid.
  - Response: stages 0 and 1 become invalid with data 0; stages 2 and 3 advance normally; inflight drops from 4 to 2 at the next edge.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle with all stages valid and retired=0x00FF.
  - Response: stage_valid=0, stage_data all 0, inflight=0, retired=0 after that edge; in_ready=1 when hold=0.
- Counter wrap:
  - Stimulus: CNT_W=4, retire 17 items.
  - Response: retired = 1; hold[3]=1 for 3 cycles with a valid last stage adds 0 to retired.
